// File: rtl/calc2_req_issuer.sv
// calc2_req_issuer: takes whole ops over valid/ready, allocates one of
// four tags, drives the two-cycle calc2 request and matches responses.
// Ports: c_clk/reset (async, low); in_valid/in_ready/in_cmd/in_op1/in_op2
// op input; req_cmd_out/req_data_out/req_tag_out to calc2; resp_in/
// resp_data_in/resp_tag_in from calc2; res_valid/res_status/res_data/
// res_tag result pulse; tags_busy count; spurious_err sticky flag.
// Optional CALC2_ISSUER_STATS_EN: stat_issued/stat_errors/stat_timeouts.
module calc2_req_issuer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cmd,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  output logic [1:0]  req_tag_out,
  input  logic [1:0]  resp_in,
  input  logic [31:0] resp_data_in,
  input  logic [1:0]  resp_tag_in,
  output logic        res_valid,
  output logic [1:0]  res_status,
  output logic [31:0] res_data,
  output logic [1:0]  res_tag,
  output logic [2:0]  tags_busy,
  output logic        spurious_err
`ifdef CALC2_ISSUER_STATS_EN
  ,
  output logic [15:0] stat_issued,
  output logic [15:0] stat_errors,
  output logic [15:0] stat_timeouts
`endif
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]       busy, started, expired;
  logic [3:0]       free_vec, alloc_vec, busy_nxt;
  logic [CNT_W-1:0] cnt [4];
  logic [31:0]      op2_q;
  logic [1:0]       cur_tag, alloc_tag, exp_tag;
  logic             accept, resp_hit, resp_bad, any_exp;
  logic [1:0]       rstat;

  function automatic logic [2:0] popcnt(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  assign accept   = in_valid && in_ready;
  assign resp_hit = (resp_in != 2'b00) && busy[resp_tag_in];
  assign resp_bad = (resp_in != 2'b00) && !busy[resp_tag_in];
  assign rstat    = (resp_in == 2'b11) ? 2'b10 : resp_in;
  assign any_exp  = |expired;

  // Counter only runs once DATA was driven, so started marks live timers.
  always_comb begin
    expired = 4'b0;
    for (int i = 0; i < 4; i++)
      expired[i] = started[i] && (cnt[i] == TMO);
  end

  always_comb begin
    alloc_tag = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!busy[i]) alloc_tag = 2'(i);
  end

  always_comb begin
    exp_tag = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (expired[i]) exp_tag = 2'(i);
  end

  // A real response always beats a pending timeout report.
  always_comb begin
    free_vec = 4'b0;
    if (resp_hit)
      free_vec[resp_tag_in] = 1'b1;
    else if (any_exp)
      free_vec[exp_tag] = 1'b1;
  end

  always_comb begin
    alloc_vec = 4'b0;
    if (accept) alloc_vec[alloc_tag] = 1'b1;
    busy_nxt = (busy & ~free_vec) | alloc_vec;
  end

  always_comb begin
    state_nxt = IDLE;
    if (accept)
      state_nxt = CMD;
    else if (state == CMD)
      state_nxt = DATA;
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      busy         <= 4'b0;
      started      <= 4'b0;
      op2_q        <= '0;
      cur_tag      <= '0;
      in_ready     <= 1'b0;
      req_cmd_out  <= '0;
      req_data_out <= '0;
      req_tag_out  <= '0;
      res_valid    <= 1'b0;
      res_status   <= '0;
      res_data     <= '0;
      res_tag      <= '0;
      tags_busy    <= '0;
      spurious_err <= 1'b0;
      for (int i = 0; i < 4; i++)
        cnt[i] <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= busy_nxt;
      tags_busy <= popcnt(busy_nxt);
      in_ready  <= (state_nxt != CMD) && (busy_nxt != 4'hF);
      if (resp_bad) spurious_err <= 1'b1;

      for (int i = 0; i < 4; i++) begin
        if (free_vec[i]) begin
          started[i] <= 1'b0;
          cnt[i]     <= '0;
        end else if (started[i] && !expired[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end

      if (accept) begin
        req_cmd_out  <= in_cmd;
        req_data_out <= in_op1;
        req_tag_out  <= alloc_tag;
        cur_tag      <= alloc_tag;
        op2_q        <= in_op2;
      end else begin
        unique case (state)
          CMD: begin
            req_cmd_out  <= '0;
            req_data_out <= op2_q;
            req_tag_out  <= '0;
            // Tag answered while still in CMD is already gone.
            if (!free_vec[cur_tag]) begin
              started[cur_tag] <= 1'b1;
              cnt[cur_tag]     <= '0;
            end
          end
          default: begin
            req_cmd_out  <= '0;
            req_data_out <= '0;
            req_tag_out  <= '0;
          end
        endcase
      end

      if (resp_hit) begin
        res_valid  <= 1'b1;
        res_status <= rstat;
        res_data   <= resp_data_in;
        res_tag    <= resp_tag_in;
      end else if (any_exp) begin
        res_valid  <= 1'b1;
        res_status <= 2'b11;
        res_data   <= '0;
        res_tag    <= exp_tag;
      end else begin
        res_valid  <= 1'b0;
        res_status <= '0;
        res_data   <= '0;
        res_tag    <= '0;
      end
    end
  end

`ifdef CALC2_ISSUER_STATS_EN
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      stat_issued   <= '0;
      stat_errors   <= '0;
      stat_timeouts <= '0;
    end else begin
      if (accept && stat_issued != 16'hFFFF)
        stat_issued <= stat_issued + 16'd1;
      if (resp_hit && rstat == 2'b10 && stat_errors != 16'hFFFF)
        stat_errors <= stat_errors + 16'd1;
      if (!resp_hit && any_exp && stat_timeouts != 16'hFFFF)
        stat_timeouts <= stat_timeouts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_calc2_req_issuer.sv
// tb_calc2_req_issuer: directed plan plus random traffic, checked
// against a tag/deadline reference model kept in the bench.
module tb_calc2_req_issuer;

  localparam int T = 16;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cmd = '0;
  logic [31:0] in_op1 = '0;
  logic [31:0] in_op2 = '0;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  req_tag_out;
  logic [1:0]  resp_in = '0;
  logic [31:0] resp_data_in = '0;
  logic [1:0]  resp_tag_in = '0;
  logic        res_valid;
  logic [1:0]  res_status;
  logic [31:0] res_data;
  logic [1:0]  res_tag;
  logic [2:0]  tags_busy;
  logic        spurious_err;

  calc2_req_issuer #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .c_clk(c_clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_op1(in_op1), .in_op2(in_op2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .req_tag_out(req_tag_out),
    .resp_in(resp_in), .resp_data_in(resp_data_in),
    .resp_tag_in(resp_tag_in),
    .res_valid(res_valid), .res_status(res_status),
    .res_data(res_data), .res_tag(res_tag),
    .tags_busy(tags_busy), .spurious_err(spurious_err)
  );

  always #5 c_clk = ~c_clk;

  int checks = 0;
  int errors = 0;

  bit          mbusy [4];
  int          mdue  [4];
  int          mphase;
  int          n = 0;
  int          mcnt;
  bit          mready;
  bit          msp;
  bit          macc;
  logic [31:0] mop2;
  logic [3:0]  e_cmd;
  logic [31:0] e_data;
  logic [1:0]  e_tag;
  bit          e_rv;
  logic [1:0]  e_rs;
  logic [31:0] e_rd;
  logic [1:0]  e_rt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int t = 0; t < 4; t++) begin
      mbusy[t] = 1'b0;
      mdue[t]  = 0;
    end
    mphase = 0; mready = 0; msp = 0; macc = 0; mcnt = 0;
    e_cmd = '0; e_data = '0; e_tag = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_cmd"}, req_cmd_out, 0);
    chk({tag, "_data"}, req_data_out, 0);
    chk({tag, "_tag"}, req_tag_out, 0);
    chk({tag, "_rv"}, res_valid, 0);
    chk({tag, "_rs"}, res_status, 0);
    chk({tag, "_rd"}, res_data, 0);
    chk({tag, "_rt"}, res_tag, 0);
    chk({tag, "_busy"}, tags_busy, 0);
    chk({tag, "_sp"}, spurious_err, 0);
  endtask

  // Predict one edge from the current inputs, then check after it.
  task automatic step();
    int a, fr;
    macc = in_valid && mready;
    e_rv = 0; e_rs = '0; e_rd = '0; e_rt = '0; fr = -1;
    if (resp_in != 0 && mbusy[resp_tag_in]) begin
      e_rv = 1;
      e_rs = (resp_in == 2'd3) ? 2'd2 : resp_in;
      e_rd = resp_data_in;
      e_rt = resp_tag_in;
      fr   = resp_tag_in;
    end else begin
      if (resp_in != 0) msp = 1;
      for (int t = 0; t < 4; t++)
        if (fr < 0 && mbusy[t] && n >= mdue[t]) begin
          e_rv = 1; e_rs = 2'd3; e_rd = '0; e_rt = 2'(t); fr = t;
        end
    end
    a = -1;
    for (int t = 0; t < 4; t++)
      if (a < 0 && !mbusy[t]) a = t;
    if (fr >= 0) mbusy[fr] = 0;
    if (macc) begin
      mbusy[a] = 1;
      mdue[a]  = n + T + 2;
      mphase   = 1;
      e_cmd = in_cmd; e_data = in_op1; e_tag = 2'(a);
      mop2  = in_op2;
    end else if (mphase == 1) begin
      mphase = 2;
      e_cmd = '0; e_data = mop2; e_tag = '0;
    end else begin
      mphase = 0;
      e_cmd = '0; e_data = '0; e_tag = '0;
    end
    mcnt = 0;
    for (int t = 0; t < 4; t++) mcnt += int'(mbusy[t]);
    mready = (mphase != 1) && (mcnt < 4);
    n++;
    @(posedge c_clk);
    #1;
    chk("req_cmd", req_cmd_out, e_cmd);
    chk("req_data", req_data_out, e_data);
    chk("req_tag", req_tag_out, e_tag);
    chk("res_valid", res_valid, e_rv);
    if (e_rv) begin
      chk("res_status", res_status, e_rs);
      chk("res_data", res_data, e_rd);
      chk("res_tag", res_tag, e_rt);
    end
    chk("tags_busy", tags_busy, mcnt);
    chk("in_ready", in_ready, mready);
    chk("spurious_err", spurious_err, msp);
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b);
    in_valid = 1; in_cmd = c; in_op1 = a; in_op2 = b;
    for (int k = 0; k < 40; k++) begin
      step();
      if (macc) break;
    end
    chk("issue_accepted", macc, 1);
    in_valid = 0;
  endtask

  task automatic respond(input logic [1:0] r, input logic [1:0] t,
                         input logic [31:0] d);
    resp_in = r; resp_tag_in = t; resp_data_in = d;
    step();
    resp_in = '0; resp_tag_in = '0; resp_data_in = '0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    mreset();
    #1;
    chk_all_zero("reset");
    #7 reset = 1;

    // 1: single add, answered after the request finishes
    step();
    issue(4'd1, 32'h30, 32'h20);
    chk("t1_cmd", req_cmd_out, 1);
    chk("t1_op1", req_data_out, 32'h30);
    chk("t1_tag", req_tag_out, 0);
    step();
    chk("t1_op2", req_data_out, 32'h20);
    step();
    respond(2'b01, 2'd0, 32'h50);
    chk("t1_rv", res_valid, 1);
    chk("t1_rs", res_status, 1);
    chk("t1_rd", res_data, 32'h50);
    chk("t1_rt", res_tag, 0);
    chk("t1_busy", tags_busy, 0);

    // 2: fill all four tags, fifth op stalls
    for (int i = 0; i < 4; i++) begin
      issue(4'd2, $urandom, $urandom);
      chk("t2_tag", req_tag_out, i);
    end
    in_valid = 1;
    idle(3);
    chk("t2_full", tags_busy, 4);
    chk("t2_stall", in_ready, 0);
    in_valid = 0;

    // 3: out-of-order answers, freed tag 0 reused
    respond(2'b10, 2'd2, 32'h1234);
    chk("t3_rt2", res_tag, 2);
    chk("t3_rs2", res_status, 2);
    respond(2'b01, 2'd0, 32'h7);
    chk("t3_rt0", res_tag, 0);
    chk("t3_rs0", res_status, 1);
    chk("t3_rd0", res_data, 32'h7);
    issue(4'd5, $urandom, $urandom);
    chk("t3_reuse", req_tag_out, 0);
    idle(30);

    // 4: timeout then late answer is spurious
    chk("t4_sp0", spurious_err, 0);
    issue(4'd6, 32'h11, 32'h22);
    idle(T + 1);
    step();
    chk("t4_rv", res_valid, 1);
    chk("t4_rs", res_status, 3);
    chk("t4_rt", res_tag, 0);
    chk("t4_rd", res_data, 0);
    respond(2'b01, 2'd0, 32'h99);
    chk("t4_sp1", spurious_err, 1);

    // 5: response for tag 0 lands on tag 1's timeout cycle
    issue(4'd1, $urandom, $urandom);
    issue(4'd1, $urandom, $urandom);
    respond(2'b01, 2'd0, 32'h5);
    issue(4'd2, $urandom, $urandom);
    for (int k = 0; k < 40 && n < mdue[1]; k++) step();
    respond(2'b01, 2'd0, 32'hABC);
    chk("t5_first_tag", res_tag, 0);
    chk("t5_first_rs", res_status, 1);
    step();
    chk("t5_next_rv", res_valid, 1);
    chk("t5_next_tag", res_tag, 1);
    chk("t5_next_rs", res_status, 3);
    idle(25);

    // 6: reset with 3 tags busy and FSM in CMD
    issue(4'd1, $urandom, $urandom);
    issue(4'd1, $urandom, $urandom);
    issue(4'd1, $urandom, $urandom);
    #2 reset = 0;
    #1;
    chk_all_zero("t6_reset");
    mreset();
    #1 reset = 1;
    respond(2'b01, 2'd1, 32'h3);
    chk("t6_sp", spurious_err, 1);
    issue(4'd2, $urandom, $urandom);
    chk("t6_tag", req_tag_out, 0);
    chk("t6_busy", tags_busy, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_cmd   = 4'($urandom);
      in_op1   = $urandom;
      in_op2   = $urandom;
      if ($urandom_range(0, 3) == 0)
        resp_in = 2'($urandom_range(1, 3));
      else
        resp_in = '0;
      resp_tag_in  = 2'($urandom);
      resp_data_in = $urandom;
      step();
    end
    in_valid = 0;
    resp_in  = '0;
    idle(25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
